// File: rtl/nand_cmd_sequencer.sv
// nand_cmd_sequencer: queues host commands and sequences them onto a shared
// multi-die NAND bus (CLE/ALE/wEn/rEn strobes, per-die cEn and ready/busy).
// Optional feature macro: NAND_STATUS_POLL_EN. When defined, a PROGRAM/ERASE
// that finishes its busy wait without timeout is followed by a 70h status
// command and one read beat; the status word is returned and bit0 flags error.
// Handshakes (req and rsp): a transfer happens on a clk edge where valid and
// ready are both 1; the source holds valid and payload stable until then.
module nand_cmd_sequencer #(
  parameter int DIO_WIDTH    = 16,
  parameter int NUM_CE       = 2,
  parameter int ADDR_CYCLES  = 3,
  parameter int QUEUE_DEPTH  = 4,
  parameter int TWAIT        = 2,
  parameter int BUSY_TIMEOUT = 1024,
  localparam int CE_W = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [CE_W-1:0]        req_ce,
  input  logic [8*ADDR_CYCLES-1:0] req_addr,
  input  logic [DIO_WIDTH-1:0]   req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DIO_WIDTH-1:0]   rsp_rdata,
  output logic                   rsp_error,
  output logic [DIO_WIDTH-1:0]   dio_out,
  output logic                   dio_oe,
  input  logic [DIO_WIDTH-1:0]   dio_in,
  output logic                   cle,
  output logic                   ale,
  output logic                   wEn,
  output logic                   rEn,
  output logic [NUM_CE-1:0]      cEn,
  input  logic [NUM_CE-1:0]      status,
  output logic [3:0]             fsm_state
);

  localparam int AW   = 8*ADDR_CYCLES;
  localparam int QW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int PW   = $clog2(2*TWAIT);
  localparam int BW   = $clog2(BUSY_TIMEOUT+1);
  localparam int AC_W = (ADDR_CYCLES > 1) ? $clog2(ADDR_CYCLES) : 1;

  localparam logic [QW:0]      Q_FULL    = (QW+1)'(QUEUE_DEPTH);
  localparam logic [PW-1:0]    PH_LAST   = PW'(2*TWAIT-1);
  localparam logic [PW-1:0]    PH_SAMPLE = PW'(TWAIT-1);
  localparam logic [PW-1:0]    PH_HIGH   = PW'(TWAIT);
  localparam logic [BW-1:0]    BT_LAST   = BW'(BUSY_TIMEOUT-1);
  localparam logic [BW-1:0]    T_WB      = BW'(2);
  localparam logic [AC_W-1:0]  AC_LAST   = AC_W'(ADDR_CYCLES-1);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_PROG  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD1, S_ADDR, S_DATA_W, S_CMD2, S_WAIT_BUSY, S_DATA_R, S_DONE,
    S_STAT_CMD, S_STAT_RD
  } state_t;

  state_t state, state_next;

  logic [1:0]           q_op    [QUEUE_DEPTH];
  logic [CE_W-1:0]      q_ce    [QUEUE_DEPTH];
  logic [AW-1:0]        q_addr  [QUEUE_DEPTH];
  logic [DIO_WIDTH-1:0] q_wdata [QUEUE_DEPTH];
  logic [QW-1:0]        wr_ptr, rd_ptr;
  logic [QW:0]          count;

  logic [1:0]           cur_op;
  logic [CE_W-1:0]      cur_ce;
  logic [AW-1:0]        cur_addr;
  logic [DIO_WIDTH-1:0] cur_wdata;
  logic [PW-1:0]        phase;
  logic [AC_W-1:0]      addr_cnt;
  logic [BW-1:0]        busy_cnt;

  logic push, pop, beat_end, wr_beat, rd_beat, sel, timeout;
  logic [7:0] cmd_byte;

  assign beat_end  = (phase == PH_LAST);
  assign req_ready = (count != Q_FULL) || pop;
  assign push      = req_valid && req_ready;
  assign fsm_state = state;

  // FIFO storage: written on enqueue only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr]    <= req_op;
      q_ce[wr_ptr]    <= req_ce;
      q_addr[wr_ptr]  <= req_addr;
      q_wdata[wr_ptr] <= req_wdata;
    end
  end

  // State register, FIFO pointers, beat/address/busy counters and response.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      phase     <= '0;
      addr_cnt  <= '0;
      busy_cnt  <= '0;
      cur_op    <= OP_RESET;
      cur_ce    <= '0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      phase    <= ((wr_beat || rd_beat) && !beat_end) ? phase + 1'b1 : '0;
      busy_cnt <= (state == S_WAIT_BUSY) ? busy_cnt + 1'b1 : '0;
      if (pop) begin
        cur_op    <= q_op[rd_ptr];
        cur_ce    <= q_ce[rd_ptr];
        cur_addr  <= q_addr[rd_ptr];
        cur_wdata <= q_wdata[rd_ptr];
        addr_cnt  <= '0;
        rsp_rdata <= '0;
        rsp_error <= 1'b0;
      end
      // Address bytes go out LSB first: shift the next byte down after each beat.
      if (state == S_ADDR && beat_end) begin
        cur_addr <= cur_addr >> 8;
        addr_cnt <= addr_cnt + 1'b1;
      end
      if (timeout) rsp_error <= 1'b1;
      // Read data is captured on the last cycle rEn is low.
      if (rd_beat && phase == PH_SAMPLE) begin
        rsp_rdata <= dio_in;
`ifdef NAND_STATUS_POLL_EN
        if (state == S_STAT_RD) rsp_error <= dio_in[0];
`endif
      end
    end
  end

  // Next-state decode and bus/strobe outputs for the current state.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    wr_beat    = 1'b0;
    rd_beat    = 1'b0;
    sel        = 1'b0;
    timeout    = 1'b0;
    cmd_byte   = 8'h00;
    cle        = 1'b0;
    ale        = 1'b0;
    wEn        = 1'b1;
    rEn        = 1'b1;
    cEn        = '1;
    dio_oe     = 1'b0;
    dio_out    = '0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = S_CMD1;
        end
      end
      S_CMD1: begin
        wr_beat = 1'b1;
        cle     = 1'b1;
        case (cur_op)
          2'b00:   cmd_byte = 8'hFF;
          2'b01:   cmd_byte = 8'h00;
          2'b10:   cmd_byte = 8'h80;
          default: cmd_byte = 8'h60;
        endcase
        dio_out[7:0] = cmd_byte;
        if (beat_end) state_next = (cur_op == OP_RESET) ? S_WAIT_BUSY : S_ADDR;
      end
      S_ADDR: begin
        wr_beat      = 1'b1;
        ale          = 1'b1;
        dio_out[7:0] = cur_addr[7:0];
        if (beat_end && addr_cnt == AC_LAST)
          state_next = (cur_op == OP_PROG) ? S_DATA_W : S_CMD2;
      end
      S_DATA_W: begin
        wr_beat = 1'b1;
        dio_out = cur_wdata;
        if (beat_end) state_next = S_CMD2;
      end
      S_CMD2: begin
        wr_beat = 1'b1;
        cle     = 1'b1;
        case (cur_op)
          2'b01:   cmd_byte = 8'h30;
          2'b10:   cmd_byte = 8'h10;
          default: cmd_byte = 8'hD0;
        endcase
        dio_out[7:0] = cmd_byte;
        if (beat_end) state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        sel = 1'b1;
        // Status is not trusted for the first two cycles (tWB).
        if (busy_cnt >= T_WB && status[cur_ce]) begin
          if (cur_op == OP_READ) state_next = S_DATA_R;
`ifdef NAND_STATUS_POLL_EN
          else if (cur_op != OP_RESET) state_next = S_STAT_CMD;
`endif
          else state_next = S_DONE;
        end else if (busy_cnt == BT_LAST) begin
          timeout    = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DATA_R: begin
        rd_beat = 1'b1;
        if (beat_end) state_next = S_DONE;
      end
`ifdef NAND_STATUS_POLL_EN
      S_STAT_CMD: begin
        wr_beat      = 1'b1;
        cle          = 1'b1;
        dio_out[7:0] = 8'h70;
        if (beat_end) state_next = S_STAT_RD;
      end
      S_STAT_RD: begin
        rd_beat = 1'b1;
        if (beat_end) state_next = S_DONE;
      end
`endif
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (wr_beat) begin
      sel    = 1'b1;
      dio_oe = 1'b1;
      wEn    = (phase >= PH_HIGH);
    end
    if (rd_beat) begin
      sel = 1'b1;
      rEn = (phase >= PH_HIGH);
    end
    if (sel) cEn[cur_ce] = 1'b0;
  end

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// tb_nand_cmd_sequencer: directed bench for nand_cmd_sequencer.
// Bus write beats are logged by a monitor and compared against an expected
// beat queue built from the command list; responses and timing are checked
// against hand-derived values.
module tb_nand_cmd_sequencer;

  localparam int DW = 16, NCE = 2, AC = 3, QD = 4, TW = 2, BT = 1024;
  localparam int BEAT = 2*TW;
  localparam int RW = NCE + 3 + DW;
  localparam logic [1:0] OP_RESET = 2'b00, OP_READ = 2'b01, OP_PROG = 2'b10, OP_ERASE = 2'b11;
`ifdef NAND_STATUS_POLL_EN
  localparam bit POLL = 1'b1;
`else
  localparam bit POLL = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic Reset = 1'b0;
  always #5 clk = ~clk;

  logic            req_valid = 1'b0, req_ready;
  logic [1:0]      req_op = 2'b00;
  logic [0:0]      req_ce = 1'b0;
  logic [8*AC-1:0] req_addr = '0;
  logic [DW-1:0]   req_wdata = '0;
  logic            rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic [DW-1:0]   rsp_rdata, dio_out, dio_in = 16'hDEAD;
  logic            dio_oe, cle, ale, wEn, rEn;
  logic [NCE-1:0]  cEn, status = '1;
  logic [3:0]      fsm_state;

  nand_cmd_sequencer #(
    .DIO_WIDTH(DW), .NUM_CE(NCE), .ADDR_CYCLES(AC), .QUEUE_DEPTH(QD),
    .TWAIT(TW), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_ce(req_ce), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in),
    .cle(cle), .ale(ale), .wEn(wEn), .rEn(rEn), .cEn(cEn), .status(status),
    .fsm_state(fsm_state)
  );

  // scoreboard state
  int total = 0, bad = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] obs_q[$];
  int tick = 0, last_oe_tick = 0, rd_beats = 0, bad_width = 0, wen_run = 0;
  logic wen_q = 1'b1, ren_q = 1'b1;

  always @(posedge clk) tick <= tick + 1;

  // bus monitor: logs each write beat at its wEn falling edge
  always @(negedge clk) begin
    if (!wEn && wen_q) obs_q.push_back({cEn, dio_oe, cle, ale, dio_out});
    if (!rEn && ren_q) rd_beats++;
    if (!wEn) wen_run++;
    else begin
      if (!wen_q && wen_run != TW) bad_width++;
      wen_run = 0;
    end
    if (dio_oe) last_oe_tick = tick;
    wen_q = wEn;
    ren_q = rEn;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [RW-1:0] beat(input int ce, input logic c, input logic a, input logic [DW-1:0] d);
    logic [NCE-1:0] cen;
    cen = '1;
    cen[ce] = 1'b0;
    return {cen, 1'b1, c, a, d};
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [1:0] op, input logic [DW-1:0] rd);
    if (op == OP_READ) return rd;
    if (POLL && (op == OP_PROG || op == OP_ERASE)) return rd;
    return '0;
  endfunction

  function automatic logic exp_err(input logic [1:0] op, input logic [DW-1:0] rd);
    return POLL && (op == OP_PROG || op == OP_ERASE) && rd[0];
  endfunction

  task automatic expect_cmd(input logic [1:0] op, input int ce, input logic [23:0] addr,
                            input logic [15:0] wd, input bit timed_out);
    logic [7:0] c1, c2;
    case (op)
      OP_RESET: begin c1 = 8'hFF; c2 = 8'h00; end
      OP_READ:  begin c1 = 8'h00; c2 = 8'h30; end
      OP_PROG:  begin c1 = 8'h80; c2 = 8'h10; end
      default:  begin c1 = 8'h60; c2 = 8'hD0; end
    endcase
    exp_q.push_back(beat(ce, 1'b1, 1'b0, {8'h00, c1}));
    if (op != OP_RESET) begin
      for (int i = 0; i < AC; i++) exp_q.push_back(beat(ce, 1'b0, 1'b1, {8'h00, addr[8*i +: 8]}));
      if (op == OP_PROG) exp_q.push_back(beat(ce, 1'b0, 1'b0, wd));
      exp_q.push_back(beat(ce, 1'b1, 1'b0, {8'h00, c2}));
      if (POLL && !timed_out && op != OP_READ) exp_q.push_back(beat(ce, 1'b1, 1'b0, 16'h0070));
    end
  endtask

  task automatic check_beats(input string tag);
    check({tag, "_nbeats"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_beat"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  // driver: enqueue one command; returns one posedge after acceptance (+#1)
  task automatic push(input logic [1:0] op, input int ce, input logic [23:0] addr, input logic [15:0] wd);
    int n;
    n = 0;
    req_op = op; req_ce = 1'(ce); req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 200) begin n++; @(negedge clk); end
    check("push_accept", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // driver: wait for a response while driving status and read data, then accept it
  task automatic wait_rsp(input int budget, input int low_ce, input int low_start, input int low_len,
                          input logic [15:0] rd, output int cyc, output logic [15:0] rdata,
                          output logic err, output int t_rsp);
    int run;
    bit seen;
    run = 0; seen = 1'b0; cyc = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      status = '1;
      if (cyc >= low_start && cyc < low_start + low_len) status[low_ce] = 1'b0;
      if (!rEn) run++; else run = 0;
      dio_in = (run == TW) ? rd : 16'hDEAD;
      if (rsp_valid) seen = 1'b1;
    end
    check("rsp_seen", 32'(seen), 1);
    rdata = rsp_rdata;
    err   = rsp_error;
    t_rsp = tick;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    dio_in = 16'hDEAD;
  endtask

  logic [1:0]  l_op [5] = '{OP_RESET, OP_ERASE, OP_READ, OP_PROG, OP_READ};
  int          l_ce [5] = '{1, 0, 1, 0, 0};
  logic [23:0] l_ad [5] = '{24'h000000, 24'h0A0B0C, 24'h112233, 24'h445566, 24'h778899};
  logic [15:0] l_wd [5] = '{16'h0000, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000};
  logic [15:0] l_rd [5] = '{16'h1110, 16'h2220, 16'h3330, 16'h4440, 16'h5550};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, t_rsp, n, vcnt, ccnt;
    logic [15:0] rdata;
    logic err;
    logic [63:0] snap, now_v;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cen", 32'(cEn), 32'(2'b11));
    check("rst_strobes", {27'b0, wEn, rEn, cle, ale, dio_oe}, 32'b11000);
    check("rst_dio_out", 32'(dio_out), 0);
    check("rst_rsp", {15'b0, rsp_valid, rsp_error, rsp_rdata}, 0);
    @(posedge clk); #1;
    Reset = 1'b1;
    @(posedge clk); #1;

    // READ ce1 addr 030201, status ready, data BEEF
    rd_beats = 0;
    push(OP_READ, 1, 24'h030201, 16'h0000);
    expect_cmd(OP_READ, 1, 24'h030201, 16'h0000, 1'b0);
    wait_rsp(200, 0, 0, 0, 16'hBEEF, cyc, rdata, err, t_rsp);
    check("read_latency", cyc, 1 + 6*BEAT + 3 + 1);
    check("read_rdata", 32'(rdata), 32'hBEEF);
    check("read_err", 32'(err), 0);
    check("read_rbeats", rd_beats, 1);
    check_beats("read");

    // PROGRAM ce0 data 1234, status low from CMD2 start for 4+50 cycles
    rd_beats = 0;
    push(OP_PROG, 0, 24'h0C0B0A, 16'h1234);
    expect_cmd(OP_PROG, 0, 24'h0C0B0A, 16'h1234, 1'b0);
    wait_rsp(400, 0, 22, 54, 16'h0001, cyc, rdata, err, t_rsp);
    check("prog_latency", cyc, 22 + 54 + 1 + (POLL ? 2*BEAT : 0));
    check("prog_rdata", 32'(rdata), 32'(exp_rd(OP_PROG, 16'h0001)));
    check("prog_err", 32'(err), 32'(exp_err(OP_PROG, 16'h0001)));
    check("prog_rbeats", rd_beats, POLL ? 1 : 0);
    check_beats("prog");

    // ERASE ce1 with status stuck low times out; queued RESET ce0 still runs
    push(OP_ERASE, 1, 24'h0A0B0C, 16'h0000);
    push(OP_RESET, 0, 24'h000000, 16'h0000);
    expect_cmd(OP_ERASE, 1, 24'h0A0B0C, 16'h0000, 1'b1);
    expect_cmd(OP_RESET, 0, 24'h000000, 16'h0000, 1'b0);
    wait_rsp(BT + 200, 1, 1, 100000, 16'h0000, cyc, rdata, err, t_rsp);
    check("tmo_err", 32'(err), 1);
    check("tmo_rdata", 32'(rdata), 0);
    check("tmo_cycles", t_rsp - last_oe_tick - 1, BT);
    wait_rsp(200, 0, 0, 0, 16'h0000, cyc, rdata, err, t_rsp);
    check("after_tmo_err", 32'(err), 0);
    check("after_tmo_rdata", 32'(rdata), 0);
    check_beats("tmo");

    // queue full: busy RESET on ce0, four queued, fifth stalls until a pop
    status = 2'b10;
    push(OP_RESET, 0, 24'h000000, 16'h0000);
    expect_cmd(OP_RESET, 0, 24'h000000, 16'h0000, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 4; i++) begin
      push(l_op[i], l_ce[i], l_ad[i], l_wd[i]);
      expect_cmd(l_op[i], l_ce[i], l_ad[i], l_wd[i], 1'b0);
    end
    expect_cmd(l_op[4], l_ce[4], l_ad[4], l_wd[4], 1'b0);
    @(negedge clk);
    check("full_ready_low", 32'(req_ready), 0);
    req_op = l_op[4]; req_ce = 1'(l_ce[4]); req_addr = l_ad[4]; req_wdata = l_wd[4];
    req_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("fifth_blocked", 32'(req_ready), 0);
    status = '1;
    n = 0;
    while (!rsp_valid && n < 100) begin n++; @(negedge clk); end
    check("busy_rsp_seen", 32'(rsp_valid), 1);
    check("done_cen", 32'(cEn), 32'(2'b11));
    check("busy_rsp_rdata", 32'(rsp_rdata), 0);
    check("busy_rsp_err", 32'(rsp_error), 0);
    snap = {22'b0, rsp_valid, rsp_rdata, rsp_error, cEn, wEn, rEn, cle, ale, dio_oe, req_ready, dio_out};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      now_v = {22'b0, rsp_valid, rsp_rdata, rsp_error, cEn, wEn, rEn, cle, ale, dio_oe, req_ready, dio_out};
      check("stall_hold", now_v[31:0], snap[31:0]);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin n++; @(negedge clk); end
    check("fifth_accept", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(300, 0, 0, 0, l_rd[i], cyc, rdata, err, t_rsp);
      check("order_rdata", 32'(rdata), 32'(exp_rd(l_op[i], l_rd[i])));
      check("order_err", 32'(err), 32'(exp_err(l_op[i], l_rd[i])));
    end
    check_beats("order");
    check("wen_width", bad_width, 0);

    // reset in the middle of ADDR with a second command queued
    push(OP_READ, 0, 24'h0A0B0C, 16'h0000);
    push(OP_ERASE, 1, 24'h010203, 16'h0000);
    n = 0;
    @(negedge clk);
    while (!ale && n < 50) begin n++; @(negedge clk); end
    check("mid_addr_reached", 32'(ale), 1);
    @(posedge clk); #1;
    Reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_cen", 32'(cEn), 32'(2'b11));
    check("midrst_strobes", {28'b0, wEn, ale, dio_oe, rsp_valid}, 32'b1000);
    @(posedge clk); #1;
    Reset = 1'b1;
    vcnt = 0; ccnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid) vcnt++;
      if (cEn != 2'b11) ccnt++;
    end
    check("midrst_no_rsp", vcnt, 0);
    check("midrst_fifo_empty", ccnt, 0);
    obs_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
